rpg_player_move: RTL and testbench



---
 rtl/rpg_player_move.sv | 127 ++++++++++++
 tb/tb_rpg_player_move.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rpg_player_move.sv
// rpg_player_move: held W/A/S/D keys to tile-grid movement with typematic repeat, plus J action pulse
module rpg_player_move #(
  parameter int FIRST_DELAY = 15000000,
  parameter int STEP_TICKS  = 5000000,
  parameter int MAP_W       = 20,
  parameter int MAP_H       = 15,
  parameter int XW          = 5,
  parameter int YW          = 4,
  parameter int X_INIT      = 0,
  parameter int Y_INIT      = 0
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [7:0]    ascii,
  input  logic          enable,
  output logic [XW-1:0] pos_x,
  output logic [YW-1:0] pos_y,
  output logic [1:0]    facing,
  output logic          moving,
  output logic          step_pulse,
  output logic          bump_pulse,
  output logic          action_pulse
);
  localparam int MAXD = FIRST_DELAY > STEP_TICKS ? FIRST_DELAY : STEP_TICKS;
  localparam int CW = $clog2(MAXD + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_FIRST = 2'd1, S_REPEAT = 2'd2;
  localparam logic [1:0] D_UP = 2'd0, D_DOWN = 2'd1, D_LEFT = 2'd2, D_RIGHT = 2'd3;

  logic [7:0]    key_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dir_q, dir_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic [1:0]    facing_q, facing_d;
  logic          step_q, step_d, bump_q, bump_d, act_q, act_d, prev_j_q;
  logic          key_valid, key_j, do_step, blocked;
  logic [1:0]    key_dir;
  logic [CW-1:0] lim;

  // decode the registered key code into a direction
  always_comb begin
    key_valid = key_q == 8'h57 || key_q == 8'h53 || key_q == 8'h41 || key_q == 8'h44;
    key_dir   = key_q == 8'h57 ? D_UP : key_q == 8'h53 ? D_DOWN : key_q == 8'h41 ? D_LEFT : D_RIGHT;
    key_j     = key_q == 8'h4A;
    lim       = state_q == S_FIRST ? CW'(FIRST_DELAY - 1) : CW'(STEP_TICKS - 1);
  end

  // press / typematic delay / auto-repeat sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    do_step = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (!key_valid) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (state_q == S_IDLE || key_dir != dir_q) begin
      do_step = 1'b1;
      state_d = S_FIRST;
      cnt_d   = '0;
      dir_d   = key_dir;
    end else if (cnt_q == lim) begin
      do_step = 1'b1;
      state_d = S_REPEAT;
      cnt_d   = '0;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  // one step: turn to face the key, then move or bump against the map edge
  always_comb begin
    blocked  = (key_dir == D_UP && pos_y_q == '0) ||
               (key_dir == D_DOWN && pos_y_q == YW'(MAP_H - 1)) ||
               (key_dir == D_LEFT && pos_x_q == '0) ||
               (key_dir == D_RIGHT && pos_x_q == XW'(MAP_W - 1));
    facing_d = do_step ? key_dir : facing_q;
    step_d   = do_step && !blocked;
    bump_d   = do_step && blocked;
    pos_x_d  = !step_d ? pos_x_q : key_dir == D_LEFT ? pos_x_q - XW'(1) :
               key_dir == D_RIGHT ? pos_x_q + XW'(1) : pos_x_q;
    pos_y_d  = !step_d ? pos_y_q : key_dir == D_UP ? pos_y_q - YW'(1) :
               key_dir == D_DOWN ? pos_y_q + YW'(1) : pos_y_q;
    act_d    = enable && key_j && !prev_j_q;
  end

  // state registers; prev_j tracks J regardless of enable so a masked press never fires late
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      key_q    <= 8'hF0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_q    <= D_DOWN;
      pos_x_q  <= XW'(X_INIT);
      pos_y_q  <= YW'(Y_INIT);
      facing_q <= D_DOWN;
      step_q   <= 1'b0;
      bump_q   <= 1'b0;
      act_q    <= 1'b0;
      prev_j_q <= 1'b0;
    end else begin
      key_q    <= ascii;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      facing_q <= facing_d;
      step_q   <= step_d;
      bump_q   <= bump_d;
      act_q    <= act_d;
      prev_j_q <= key_j;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign facing       = facing_q;
  assign moving       = state_q != S_IDLE;
  assign step_pulse   = step_q;
  assign bump_pulse   = bump_q;
  assign action_pulse = act_q;
endmodule

// File: tb/tb_rpg_player_move.sv
// tb_rpg_player_move: scoreboard bench for rpg_player_move against a held-run-length model
module tb_rpg_player_move;
  localparam int FD = 10, ST = 4, MW = 4, MH = 3, XI = 1, YI = 1;

  typedef struct packed {
    logic [1:0] x, y, f;
    logic mv, st, bp, ac;
  } exp_t;

  logic       clk_in = 1'b0, rst_n_in = 1'b1, enable = 1'b1;
  logic [7:0] ascii = 8'hF0;
  logic [1:0] pos_x, pos_y, facing;
  logic       moving, step_pulse, bump_pulse, action_pulse;

  int checks = 0, errors = 0;
  int st_cnt, bp_cnt, ac_cnt;
  exp_t sb[$];

  logic [7:0] m_key;
  logic       m_prevj;
  int         m_n, m_x, m_y;
  logic [1:0] m_dir, m_face;

  rpg_player_move #(.FIRST_DELAY(FD), .STEP_TICKS(ST), .MAP_W(MW), .MAP_H(MH),
                    .XW(2), .YW(2), .X_INIT(XI), .Y_INIT(YI)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .ascii(ascii), .enable(enable),
    .pos_x(pos_x), .pos_y(pos_y), .facing(facing), .moving(moving),
    .step_pulse(step_pulse), .bump_pulse(bump_pulse), .action_pulse(action_pulse)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_key = 8'hF0; m_prevj = 1'b0; m_n = 0; m_x = XI; m_y = YI; m_dir = 2'd1; m_face = 2'd1;
  endtask

  // the model counts how many consecutive edges one direction has been seen with enable high
  task automatic model(input logic [7:0] a, input logic en, output exp_t e);
    logic [7:0] kq;
    logic       valid, do_st, j;
    logic [1:0] d;
    int         nx, ny;
    kq = m_key;
    m_key = a;
    valid = kq == 8'h57 || kq == 8'h53 || kq == 8'h41 || kq == 8'h44;
    d = kq == 8'h57 ? 2'd0 : kq == 8'h53 ? 2'd1 : kq == 8'h41 ? 2'd2 : 2'd3;
    j = kq == 8'h4A;
    e = '0;
    e.ac = en && j && !m_prevj;
    m_prevj = j;
    if (!en || !valid) m_n = 0;
    else if (m_n == 0 || d != m_dir) begin m_n = 1; m_dir = d; end
    else m_n++;
    do_st = m_n == 1 || m_n == 1 + FD || (m_n > 1 + FD && (m_n - 1 - FD) % ST == 0);
    if (do_st) begin
      m_face = d;
      nx = m_x + int'(d == 2'd3) - int'(d == 2'd2);
      ny = m_y + int'(d == 2'd1) - int'(d == 2'd0);
      if (nx >= 0 && nx < MW && ny >= 0 && ny < MH) begin
        m_x = nx; m_y = ny; e.st = 1'b1;
      end else e.bp = 1'b1;
    end
    e.x = 2'(m_x); e.y = 2'(m_y); e.f = m_face; e.mv = m_n > 0;
  endtask

  task automatic cyc(input logic [7:0] a, input logic en);
    exp_t e, g;
    ascii = a;
    enable = en;
    model(a, en, e);
    sb.push_back(e);
    @(negedge clk_in);
    g = sb.pop_front();
    chk("pos_x", 32'(pos_x), 32'(g.x));
    chk("pos_y", 32'(pos_y), 32'(g.y));
    chk("facing", 32'(facing), 32'(g.f));
    chk("moving", 32'(moving), 32'(g.mv));
    chk("step_pulse", 32'(step_pulse), 32'(g.st));
    chk("bump_pulse", 32'(bump_pulse), 32'(g.bp));
    chk("action_pulse", 32'(action_pulse), 32'(g.ac));
    st_cnt += int'(step_pulse);
    bp_cnt += int'(bump_pulse);
    ac_cnt += int'(action_pulse);
  endtask

  task automatic hold(input logic [7:0] a, input logic en, input int n);
    for (int i = 0; i < n; i++) cyc(a, en);
  endtask

  task automatic clr();
    st_cnt = 0; bp_cnt = 0; ac_cnt = 0;
  endtask

  task automatic rst_chk();
    chk("rst pos_x", 32'(pos_x), XI);
    chk("rst pos_y", 32'(pos_y), YI);
    chk("rst facing", 32'(facing), 1);
    chk("rst moving", 32'(moving), 0);
    chk("rst step", 32'(step_pulse), 0);
    chk("rst bump", 32'(bump_pulse), 0);
    chk("rst action", 32'(action_pulse), 0);
  endtask

  initial begin
    model_reset();
    clr();
    #2 rst_n_in = 1'b0;
    #20 rst_chk();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    hold(8'hF0, 1'b1, 3);
    rst_chk();

    clr();
    hold(8'h44, 1'b1, 30);
    chk("D steps", st_cnt, 2);
    chk("D bumps", bp_cnt, 4);
    chk("D x", 32'(pos_x), 3);
    hold(8'hF0, 1'b1, 3);

    clr();
    hold(8'h57, 1'b1, 3);
    hold(8'hF0, 1'b1, 3);
    chk("W tap steps", st_cnt, 1);
    chk("W tap y", 32'(pos_y), 0);
    clr();
    hold(8'h57, 1'b1, 3);
    hold(8'hF0, 1'b1, 2);
    chk("W tap2 steps", st_cnt, 0);
    chk("W tap2 bumps", bp_cnt, 1);

    clr();
    hold(8'h41, 1'b1, 6);
    hold(8'h53, 1'b1, 8);
    hold(8'hF0, 1'b1, 2);
    chk("A->S steps", st_cnt, 2);

    clr();
    hold(8'h4A, 1'b1, 20);
    hold(8'h44, 1'b1, 3);
    hold(8'h4A, 1'b1, 3);
    hold(8'hF0, 1'b1, 2);
    chk("J pulses", ac_cnt, 2);
    clr();
    hold(8'h4A, 1'b0, 3);
    hold(8'h4A, 1'b1, 2);
    hold(8'hF0, 1'b1, 2);
    chk("J masked pulses", ac_cnt, 0);

    hold(8'h41, 1'b1, 16);
    clr();
    cyc(8'h41, 1'b0);
    chk("en drop moving", 32'(moving), 0);
    hold(8'h41, 1'b1, 14);
    chk("re-press events", st_cnt + bp_cnt, 2);
    chk("in repeat", 32'(moving), 1);
    #2 rst_n_in = 1'b0;
    #1;
    rst_chk();
    sb.delete();
    model_reset();
    @(negedge clk_in);
    rst_chk();
    ascii = 8'hF0;
    rst_n_in = 1'b1;
    hold(8'hF0, 1'b1, 2);
    hold(8'h44, 1'b1, 3);
    hold(8'hF0, 1'b1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
